mem_interface: RTL and testbench

// - MAR/MDR memory interface stage; sits directly upstream of the datapath bus mux.
// - Its mdr_q output is the bus mux's MDR input.
// - Captures the address (MAR) and write data (MDR) from the datapath bus.
// - Runs a req/ack handshake with the word-addressed data memory.
// - Returns read data through MDR, so a multi-cycle memory can stall the control unit via busy/done.

---
 rtl/mem_interface_pkg.sv | 20 ++
 rtl/mem_interface_if.sv | 27 ++
 rtl/mem_if_reg.sv | 21 ++
 rtl/mem_interface.sv | 123 ++++++++++++
 tb/tb_mem_interface.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_interface_pkg.sv
// Shared definitions for the MAR/MDR memory interface stage: default widths,
// timeout depth and the transfer FSM state type.
package mem_interface_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 9;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_wait(input state_t s);
    return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Request/acknowledge bus between the MAR/MDR stage (master) and the
// word-addressed data memory (slave).
interface mem_interface_if
  import mem_interface_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_if_reg.sv
// Parameterised register with asynchronous clear and load enable; used for
// both MAR and MDR.
module mem_if_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR memory interface stage: captures address/data from the datapath bus
// and runs a req/ack transfer with timeout against the data memory.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              rd_start,
  input  logic              wr_start,
  output logic [DATA_W-1:0] mdr_q,
  output logic [ADDR_W-1:0] mar_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  mem_interface_if.master   mem
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] req_addr;

  logic              can_start;
  logic              rd_fill;
  logic              mar_load;
  logic              mdr_load;
  logic [DATA_W-1:0] mdr_d;

  assign can_start = !is_wait(state);
  assign rd_fill   = (state == ST_RD_WAIT) && mem.mem_ack;

  // Register loads are blocked while a transfer is outstanding; a read
  // completion takes priority over the bus for MDR.
  assign mar_load = MARin && !busy;
  assign mdr_load = (MDRin && !busy) || rd_fill;
  assign mdr_d    = rd_fill ? mem.mem_rdata : bus_in;

  mem_if_reg #(.W(ADDR_W)) u_mar (
    .clk  (clock),
    .rst  (clear),
    .load (mar_load),
    .d    (bus_in[ADDR_W-1:0]),
    .q    (mar_q)
  );

  mem_if_reg #(.W(DATA_W)) u_mdr (
    .clk  (clock),
    .rst  (clear),
    .load (mdr_load),
    .d    (mdr_d),
    .q    (mdr_q)
  );

  // A start coinciding with MARin must use the pre-edge MAR, so the address
  // is latched at acceptance and presented for the duration of the request.
  assign mem.mem_addr  = busy ? req_addr : mar_q;
  assign mem.mem_wdata = mdr_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      req_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_we   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (rd_start && wr_start) begin
            state <= ST_IDLE;
            err   <= 1'b1;
          end else if (rd_start || wr_start) begin
            state       <= wr_start ? ST_WR_WAIT : ST_RD_WAIT;
            cnt         <= '0;
            req_addr    <= mar_q;
            busy        <= 1'b1;
            mem.mem_req <= 1'b1;
            mem.mem_we  <= wr_start;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RD_WAIT, ST_WR_WAIT: begin
          if (mem.mem_ack) begin
            state       <= ST_DONE;
            done        <= 1'b1;
            busy        <= 1'b0;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= ST_IDLE;
            err         <= 1'b1;
            busy        <= 1'b0;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          mem.mem_req <= 1'b0;
          mem.mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed vector table, hand-written timeout/reset
// sequences, then random stimulus against a transaction-level model.
module tb_mem_interface;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] bus_in = '0;
  logic          MARin = 1'b0, MDRin = 1'b0, rd_start = 1'b0, wr_start = 1'b0;
  logic [DW-1:0] mdr_q;
  logic [AW-1:0] mar_q;
  logic          busy, done, err;

  mem_interface_if #(.DATA_W(DW), .ADDR_W(AW)) mif ();

  mem_interface #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clock    (clock),
    .clear    (clear),
    .bus_in   (bus_in),
    .MARin    (MARin),
    .MDRin    (MDRin),
    .rd_start (rd_start),
    .wr_start (wr_start),
    .mdr_q    (mdr_q),
    .mar_q    (mar_q),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (mif)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level reference: is a request outstanding, how many request
  // cycles it has lasted, and what address it was issued with.
  logic [AW-1:0] m_mar, m_addr;
  logic [DW-1:0] m_mdr;
  logic          m_active, m_write, m_done, m_err;
  int            m_req_cycles;

  task automatic model_reset();
    m_mar = '0; m_addr = '0; m_mdr = '0;
    m_active = 1'b0; m_write = 1'b0; m_done = 1'b0; m_err = 1'b0;
    m_req_cycles = 0;
  endtask

  task automatic model_edge();
    logic was_active;
    was_active = m_active;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_active) begin
      if (mif.mem_ack) begin
        if (!m_write) m_mdr = mif.mem_rdata;
        m_active = 1'b0;
        m_done   = 1'b1;
      end else if (m_req_cycles == TO) begin
        m_active = 1'b0;
        m_err    = 1'b1;
      end else begin
        m_req_cycles++;
      end
    end else if (rd_start && wr_start) begin
      m_err = 1'b1;
    end else if (rd_start || wr_start) begin
      m_active     = 1'b1;
      m_write      = wr_start;
      m_req_cycles = 1;
      m_addr       = m_mar;
    end
    if (!was_active) begin
      if (MARin) m_mar = bus_in[AW-1:0];
      if (MDRin) m_mdr = bus_in;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("mar_q",     32'(mar_q),         32'(m_mar));
    chk("mdr_q",     mdr_q,              m_mdr);
    chk("busy",      32'(busy),          32'(m_active));
    chk("mem_req",   32'(mif.mem_req),   32'(m_active));
    chk("mem_we",    32'(mif.mem_we),    32'(m_active && m_write));
    chk("done",      32'(done),          32'(m_done));
    chk("err",       32'(err),           32'(m_err));
    chk("mem_addr",  32'(mif.mem_addr),  32'(m_active ? m_addr : m_mar));
    chk("mem_wdata", mif.mem_wdata,      m_mdr);
  endtask

  // One clock: model follows the inputs sampled at the rising edge, outputs
  // are then observed at the falling edge.
  task automatic cycle();
    @(posedge clock);
    if (clear) model_reset();
    else model_edge();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus_in = '0; MARin = 0; MDRin = 0; rd_start = 0; wr_start = 0;
    mif.mem_ack = 0; mif.mem_rdata = '0;
  endtask

  typedef struct {
    logic [DW-1:0] bus;
    logic          marin, mdrin, rd, wr, ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] e_mar;
    logic [DW-1:0] e_mdr;
    logic          e_busy, e_we, e_done, e_err;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic vec_t mk(
    input logic [DW-1:0] bus, input logic marin, mdrin, rd, wr, ack,
    input logic [DW-1:0] rdata, input logic [AW-1:0] e_mar, input logic [DW-1:0] e_mdr,
    input logic e_busy, e_we, e_done, e_err, input logic [AW-1:0] e_addr);
    vec_t v;
    v.bus = bus; v.marin = marin; v.mdrin = mdrin; v.rd = rd; v.wr = wr; v.ack = ack;
    v.rdata = rdata; v.e_mar = e_mar; v.e_mdr = e_mdr; v.e_busy = e_busy;
    v.e_we = e_we; v.e_done = e_done; v.e_err = e_err; v.e_addr = e_addr;
    return v;
  endfunction

  vec_t tbl[19];

  initial begin
    int n;
    logic [DW-1:0] mdr_keep;
    idle_inputs();
    model_reset();

    // Each row: inputs held across one rising edge, expected outputs after it.
    //           bus           MAR MDR rd wr ack rdata          e_mar   e_mdr         bsy we dn er e_addr
    tbl[0]  = mk(32'h00000045, 1, 0, 0, 0, 0, 32'h0,          9'h045, 32'h0,        0, 0, 0, 0, 9'h045);
    tbl[1]  = mk(32'h0,        0, 0, 1, 0, 0, 32'h0,          9'h045, 32'h0,        1, 0, 0, 0, 9'h045);
    tbl[2]  = mk(32'h0,        0, 0, 0, 0, 0, 32'hDEADBEEF,   9'h045, 32'h0,        1, 0, 0, 0, 9'h045);
    tbl[3]  = mk(32'hFFFFFFFF, 1, 1, 0, 0, 0, 32'h0,          9'h045, 32'h0,        1, 0, 0, 0, 9'h045);
    tbl[4]  = mk(32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF,   9'h045, 32'hDEADBEEF, 0, 0, 1, 0, 9'h045);
    tbl[5]  = mk(32'h0,        0, 0, 0, 0, 0, 32'h0,          9'h045, 32'hDEADBEEF, 0, 0, 0, 0, 9'h045);
    tbl[6]  = mk(32'h12345678, 0, 1, 0, 0, 0, 32'h0,          9'h045, 32'h12345678, 0, 0, 0, 0, 9'h045);
    tbl[7]  = mk(32'h000001FF, 1, 0, 0, 0, 0, 32'h0,          9'h1FF, 32'h12345678, 0, 0, 0, 0, 9'h1FF);
    tbl[8]  = mk(32'h0,        0, 0, 0, 1, 0, 32'h0,          9'h1FF, 32'h12345678, 1, 1, 0, 0, 9'h1FF);
    tbl[9]  = mk(32'hFFFFFFFF, 0, 1, 0, 0, 1, 32'hAAAAAAAA,   9'h1FF, 32'h12345678, 0, 0, 1, 0, 9'h1FF);
    tbl[10] = mk(32'h0,        0, 0, 1, 0, 0, 32'h0,          9'h1FF, 32'h12345678, 1, 0, 0, 0, 9'h1FF);
    tbl[11] = mk(32'h0,        0, 0, 0, 0, 1, 32'h0BADF00D,   9'h1FF, 32'h0BADF00D, 0, 0, 1, 0, 9'h1FF);
    tbl[12] = mk(32'h0,        0, 0, 1, 1, 0, 32'h0,          9'h1FF, 32'h0BADF00D, 0, 0, 0, 1, 9'h1FF);
    tbl[13] = mk(32'h0,        0, 0, 0, 0, 0, 32'h0,          9'h1FF, 32'h0BADF00D, 0, 0, 0, 0, 9'h1FF);
    tbl[14] = mk(32'h000000AB, 1, 0, 1, 0, 0, 32'h0,          9'h0AB, 32'h0BADF00D, 1, 0, 0, 0, 9'h1FF);
    tbl[15] = mk(32'h0,        0, 0, 0, 0, 1, 32'h11111111,   9'h0AB, 32'h11111111, 0, 0, 1, 0, 9'h0AB);
    tbl[16] = mk(32'h0,        0, 0, 0, 0, 1, 32'h22222222,   9'h0AB, 32'h11111111, 0, 0, 0, 0, 9'h0AB);
    tbl[17] = mk(32'h0,        0, 0, 1, 0, 0, 32'h0,          9'h0AB, 32'h11111111, 1, 0, 0, 0, 9'h0AB);
    tbl[18] = mk(32'h55555555, 0, 1, 0, 0, 1, 32'h66666666,   9'h0AB, 32'h66666666, 0, 0, 1, 0, 9'h0AB);

    // Reset state
    clear = 1'b1;
    @(negedge clock);
    chk("rst_mar",  32'(mar_q), 32'h0);
    chk("rst_mdr",  mdr_q,      32'h0);
    chk("rst_busy", 32'(busy),  32'h0);
    chk("rst_req",  32'(mif.mem_req), 32'h0);
    chk("rst_flags", {29'h0, done, err, mif.mem_we}, 32'h0);
    clear = 1'b0;

    foreach (tbl[i]) begin
      bus_in = tbl[i].bus; MARin = tbl[i].marin; MDRin = tbl[i].mdrin;
      rd_start = tbl[i].rd; wr_start = tbl[i].wr;
      mif.mem_ack = tbl[i].ack; mif.mem_rdata = tbl[i].rdata;
      cycle();
      chk($sformatf("v%0d_mar", i),   32'(mar_q),          32'(tbl[i].e_mar));
      chk($sformatf("v%0d_mdr", i),   mdr_q,               tbl[i].e_mdr);
      chk($sformatf("v%0d_busy", i),  32'(busy),           32'(tbl[i].e_busy));
      chk($sformatf("v%0d_req", i),   32'(mif.mem_req),    32'(tbl[i].e_busy));
      chk($sformatf("v%0d_we", i),    32'(mif.mem_we),     32'(tbl[i].e_we));
      chk($sformatf("v%0d_done", i),  32'(done),           32'(tbl[i].e_done));
      chk($sformatf("v%0d_err", i),   32'(err),            32'(tbl[i].e_err));
      chk($sformatf("v%0d_addr", i),  32'(mif.mem_addr),   32'(tbl[i].e_addr));
      chk($sformatf("v%0d_wdata", i), mif.mem_wdata,       tbl[i].e_mdr);
    end
    idle_inputs();

    // Timeout: request with no ack is held TO cycles, then a single err pulse.
    mdr_keep = 32'h66666666;
    rd_start = 1'b1;
    cycle();
    rd_start = 1'b0;
    n = 0;
    while (mif.mem_req === 1'b1 && n < 40) begin
      n++;
      cycle();
    end
    chk("to_req_cycles", 32'(n),   32'(TO));
    chk("to_err",        32'(err), 32'h1);
    chk("to_busy",       32'(busy), 32'h0);
    chk("to_mdr",        mdr_q,    mdr_keep);
    cycle();
    chk("to_err_pulse",  32'(err), 32'h0);

    // Asynchronous reset in the middle of a read wait.
    rd_start = 1'b1;
    cycle();
    rd_start = 1'b0;
    chk("ar_req_before", 32'(mif.mem_req), 32'h1);
    clear = 1'b1;
    #1;
    chk("ar_req",  32'(mif.mem_req), 32'h0);
    chk("ar_busy", 32'(busy),        32'h0);
    chk("ar_mdr",  mdr_q,            32'h0);
    chk("ar_mar",  32'(mar_q),       32'h0);
    model_reset();
    cycle();
    clear = 1'b0;
    cycle();
    chk_model();

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      bus_in        = $urandom;
      MARin         = ($urandom_range(0, 3) == 0);
      MDRin         = ($urandom_range(0, 3) == 0);
      rd_start      = ($urandom_range(0, 4) == 0);
      wr_start      = ($urandom_range(0, 4) == 0);
      mif.mem_ack   = ($urandom_range(0, 5) == 0);
      mif.mem_rdata = $urandom;
      clear         = ($urandom_range(0, 149) == 0);
      cycle();
      chk_model();
    end
    idle_inputs();
    clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
